// File: rtl/keyed_fsm_pkg.sv
// Shared types and output constants for the key-locked control FSM benchmark.
package keyed_fsm_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        ACQ  = 4'd1,
        CHK  = 4'd2,
        RUN  = 4'd3,
        DONE = 4'd4,
        DUP  = 4'd5
    } state_e;

    localparam logic [7:0] Y_IDLE       = 8'h00;
    localparam logic [7:0] Y_ACQ        = 8'h01;
    localparam logic [7:0] Y_CHK        = 8'h03;
    localparam logic [7:0] Y_RUN_BASE   = 8'hA0;
    localparam logic [7:0] Y_DONE       = 8'hFF;
    localparam logic [7:0] CORRUPT_MASK = 8'h5A;

    function automatic logic [7:0] run_y(input logic [3:0] xq);
        return Y_RUN_BASE | {4'h0, xq};
    endfunction

endpackage

// File: rtl/kfsm_trig_cnt.sv
// Saturating run counter; armed_o rises once TRIG_CNT correct-key runs were seen.
module kfsm_trig_cnt #(
    parameter int CNT_W    = 8,
    parameter int TRIG_CNT = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    output logic armed_o
);

    localparam logic [CNT_W-1:0] TRIG_VAL = CNT_W'(TRIG_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: step on each qualifying run, hold once the threshold is hit.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != TRIG_VAL)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign armed_o = (cnt_q == TRIG_VAL);

endmodule

// File: rtl/keyed_fsm_ctrl.sv
// Key-locked control FSM with a duplicate RUN state that corrupts y after DUP_DEPTH cycles.
// Optional count-triggered payload enabled by defining KEYED_FSM_TROJAN_EN.
module keyed_fsm_ctrl
    import keyed_fsm_pkg::*;
#(
    parameter int               KEY_W       = 4,
    parameter logic [KEY_W-1:0] CORRECT_KEY = 4'hA,
    parameter int               DUP_DEPTH   = 3,
    parameter int               CNT_W       = 8,
    parameter int               TRIG_CNT    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       x,
    input  logic [KEY_W-1:0] keyinput,
    output logic [7:0]       y,
    output logic             done
);

    localparam int               IDX_W   = $clog2(DUP_DEPTH + 1);
    localparam logic [IDX_W-1:0] DUP_MAX = IDX_W'(DUP_DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] dup_idx_q, dup_idx_d;
    logic [3:0]       x_q;
    logic [7:0]       y_q, y_d;
    logic             done_q, done_d;
    logic             armed_s;
    logic             run_entry_s;

    function automatic logic [7:0] decode_y(input state_e st, input logic [IDX_W-1:0] idx,
                                            input logic [3:0] xq);
        logic [7:0] val;
        case (st)
            IDLE:    val = Y_IDLE;
            ACQ:     val = Y_ACQ;
            CHK:     val = Y_CHK;
            RUN:     val = run_y(xq);
            DONE:    val = Y_DONE;
            DUP: begin
                if (idx < DUP_MAX) begin
                    val = run_y(xq);
                end else begin
                    val = run_y(xq) ^ CORRUPT_MASK;
                end
            end
            default: val = Y_IDLE;
        endcase
        return val;
    endfunction

    assign run_entry_s = (state_q == CHK) && (state_d == RUN);

`ifdef KEYED_FSM_TROJAN_EN
    kfsm_trig_cnt #(
        .CNT_W    (CNT_W),
        .TRIG_CNT (TRIG_CNT)
    ) u_trig_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (run_entry_s),
        .armed_o (armed_s)
    );
`else
    assign armed_s = 1'b0;
`endif

    // Next-state logic; the key is only looked at in CHK.
    always_comb begin
        state_d   = state_q;
        dup_idx_d = dup_idx_q;
        case (state_q)
            IDLE: begin
                if (x[0]) state_d = ACQ;
                else      state_d = IDLE;
            end
            ACQ: begin
                if (x[1]) state_d = CHK;
                else      state_d = ACQ;
            end
            CHK: begin
                if ((keyinput == CORRECT_KEY) && !armed_s) begin
                    state_d = RUN;
                end else begin
                    state_d   = DUP;
                    dup_idx_d = {IDX_W{1'b0}};
                end
            end
            RUN: begin
                if (x[3]) state_d = DONE;
                else      state_d = RUN;
            end
            DONE: state_d = IDLE;
            DUP: begin
                if (dup_idx_q != DUP_MAX) dup_idx_d = dup_idx_q + IDX_ONE;
                else                      dup_idx_d = dup_idx_q;
                if (x[3]) state_d = IDLE;
                else      state_d = DUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are precomputed from next-state values so y/done come straight from flops.
    always_comb begin
        y_d    = decode_y(state_d, dup_idx_d, x);
        done_d = (state_d == DONE);
    end

    // State, duplicate index, input copy and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dup_idx_q <= {IDX_W{1'b0}};
            x_q       <= 4'h0;
            y_q       <= Y_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dup_idx_q <= dup_idx_d;
            x_q       <= x;
            y_q       <= y_d;
            done_q    <= done_d;
        end
    end

    assign y    = y_q;
    assign done = done_q;

endmodule

// File: tb/tb_keyed_fsm_ctrl.sv
// Directed self-checking bench for keyed_fsm_ctrl with hand-computed expectations.
module tb_keyed_fsm_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] x;
    logic [3:0] keyinput;
    logic [7:0] y;
    logic       done;

    int n_checks;
    int n_errors;

    keyed_fsm_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .keyinput (keyinput),
        .y        (y),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply x, clock once, then look at outputs 1 time unit after the edge.
    task automatic step(input logic [3:0] xv, input string tag,
                        input logic [7:0] exp_y, input logic exp_done);
        x = xv;
        @(posedge clk);
        #1;
        check_val({tag, ".y"}, y, exp_y);
        check_val({tag, ".done"}, {7'd0, done}, {7'd0, exp_done});
    endtask

    task automatic correct_run(input string tag);
        step(4'b0001, {tag, "_acq"},  8'h01, 1'b0);
        step(4'b0010, {tag, "_chk"},  8'h03, 1'b0);
        step(4'b0100, {tag, "_run1"}, 8'hA4, 1'b0);
        step(4'b0100, {tag, "_run2"}, 8'hA4, 1'b0);
        step(4'b1000, {tag, "_done"}, 8'hFF, 1'b1);
        step(4'b0000, {tag, "_idle"}, 8'h00, 1'b0);
    endtask

    task automatic dup_run(input string tag);
        step(4'b0001, {tag, "_acq"},  8'h01, 1'b0);
        step(4'b0010, {tag, "_chk"},  8'h03, 1'b0);
        step(4'b0100, {tag, "_dup1"}, 8'hA4, 1'b0);
        step(4'b0100, {tag, "_dup2"}, 8'hA4, 1'b0);
        step(4'b0100, {tag, "_dup3"}, 8'hA4, 1'b0);
        step(4'b0100, {tag, "_dup4"}, 8'hFE, 1'b0);
        step(4'b0100, {tag, "_dup5"}, 8'hFE, 1'b0);
        step(4'b1000, {tag, "_exit"}, 8'h00, 1'b0);
        step(4'b0000, {tag, "_idle"}, 8'h00, 1'b0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_val({tag, ".y"}, y, 8'h00);
        check_val({tag, ".done"}, {7'd0, done}, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        x        = 4'h0;
        keyinput = 4'hA;
        #1;
        check_val("reset_y", y, 8'h00);
        check_val("reset_done", {7'd0, done}, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idles until start; x[1] alone is ignored in IDLE.
        step(4'b0000, "idle0", 8'h00, 1'b0);
        step(4'b0010, "idle_x1", 8'h00, 1'b0);

        correct_run("ok");

        // x[3] on the CHK->RUN edge is not acted on.
        step(4'b0001, "x3chk_acq", 8'h01, 1'b0);
        step(4'b0010, "x3chk_chk", 8'h03, 1'b0);
        step(4'b1000, "x3chk_run", 8'hA8, 1'b0);
        step(4'b0000, "x3chk_run2", 8'hA0, 1'b0);
        step(4'b1000, "x3chk_done", 8'hFF, 1'b1);
        step(4'b0000, "x3chk_idle", 8'h00, 1'b0);

        // Key change during RUN has no effect.
        step(4'b0001, "key_acq", 8'h01, 1'b0);
        step(4'b0010, "key_chk", 8'h03, 1'b0);
        step(4'b0100, "key_run1", 8'hA4, 1'b0);
        keyinput = 4'h0;
        step(4'b0101, "key_run2", 8'hA5, 1'b0);
        step(4'b1000, "key_done", 8'hFF, 1'b1);
        step(4'b0000, "key_idle", 8'h00, 1'b0);
        keyinput = 4'hA;

        // Mid-run reset takes effect without a clock edge.
        step(4'b0001, "mid_acq", 8'h01, 1'b0);
        step(4'b0010, "mid_chk", 8'h03, 1'b0);
        step(4'b0100, "mid_run", 8'hA4, 1'b0);
        pulse_reset("mid_rst");
        step(4'b0000, "mid_idle", 8'h00, 1'b0);

        // Five runs from a clean counter, then the sixth.
        for (int i = 0; i < 5; i++) begin
            correct_run($sformatf("cnt%0d", i));
        end
`ifdef KEYED_FSM_TROJAN_EN
        dup_run("cnt5");
`else
        correct_run("cnt5");
`endif

        keyinput = 4'h3;
        dup_run("badkey");
        keyinput = 4'hA;

        // Reset at DUP cycle 4 clears everything including the trigger counter.
        keyinput = 4'h3;
        step(4'b0001, "rdup_acq", 8'h01, 1'b0);
        step(4'b0010, "rdup_chk", 8'h03, 1'b0);
        step(4'b0100, "rdup_d1", 8'hA4, 1'b0);
        step(4'b0100, "rdup_d2", 8'hA4, 1'b0);
        step(4'b0100, "rdup_d3", 8'hA4, 1'b0);
        step(4'b0100, "rdup_d4", 8'hFE, 1'b0);
        pulse_reset("rdup_rst");
        keyinput = 4'hA;
        step(4'b0000, "rdup_idle", 8'h00, 1'b0);
        correct_run("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keyed_fsm_ctrl.md
# keyed_fsm_ctrl

Parametrised key-locked control FSM, the next generation of the team's obfuscated-FSM benchmarks. A KEY_W-bit key is checked at one decision state. A correct key enters the genuine RUN state. A wrong key enters a duplicate state that mimics RUN for DUP_DEPTH cycles and then corrupts the outputs. An optional count-triggered payload diverts correct-key runs once a run threshold is reached. The block is a standalone benchmark core for locking and trojan-detection evaluation flows.

## Interface
- KEY_W, 4: key width in bits.
- CORRECT_KEY, 4'hA: unlocking key value, KEY_W bits.
- DUP_DEPTH, 3: number of cycles the duplicate state mimics RUN; must be ≥1.
- CNT_W, 8: width of the payload trigger counter.
- TRIG_CNT, 5: number of correct-key RUN entries before the payload fires; must be < 2^CNT_W.

Ports:
- clk  in  1  clock; rising edge only.
- rst_n  in  1  reset; asynchronous, active-low.
- x  in  4  control inputs: x[0] start, x[1] proceed, x[3] finish; x[2] is data only.
- keyinput  in  KEY_W  key bits; static during a run.
- y  out  8  Moore output, decoded from registered state.
- done  out  1  high for exactly one cycle while in DONE.

## Operation
- Registers: state, dup_idx (saturating at DUP_DEPTH), x_q (copy of x, captured every cycle), and trig_cnt (macro only).
- IDLE: y=8'h00. If x[0]=1, go to ACQ.
- ACQ: y=8'h01. If x[1]=1, go to CHK; otherwise stay in ACQ.
- CHK: y=8'h03. keyinput is sampled only in CHK.
  - keyinput==CORRECT_KEY and payload not armed: go to RUN.
  - Otherwise: go to DUP, with dup_idx cleared to 0.
- RUN: y=8'hA0|{4'h0,x_q}. If x[3]=1, go to DONE; otherwise stay in RUN.
- DONE: y=8'hFF, done=1. Always go to IDLE on the next edge.
- DUP: y depends on dup_idx.
  - dup_idx<DUP_DEPTH: y equals the RUN value.
  - dup_idx==DUP_DEPTH: y=(8'hA0|{4'h0,x_q})^8'h5A.
  - dup_idx increments each cycle in DUP and saturates at DUP_DEPTH.
  - If x[3]=1, go to IDLE; done is never asserted from DUP.
- Unused state encodings: go to IDLE on the next edge, with y=8'h00.
- Key changes outside CHK have no effect.
- x[0] and x[1] are ignored outside IDLE and ACQ respectively.

## Timing
- All state updates occur on the rising clk edge.
- x sampled at edge k appears in y after edge k, via x_q (1-cycle latency).
- rst_n low takes effect immediately, without waiting for a clock edge:
  - state=IDLE, dup_idx=0, x_q=0, trig_cnt=0.
  - Outputs: y=8'h00, done=0.
  - Reset during any state, including DUP or DONE, aborts the run; trig_cnt is cleared.
- Minimum correct run is 5 cycles: IDLE→ACQ→CHK→RUN→DONE.
- DUP mimics RUN for exactly DUP_DEPTH cycles after entry. Corruption starts in cycle DUP_DEPTH+1 and persists until exit.
- If x[3] is high on the CHK→DUP or CHK→RUN edge, it is not acted on. The exit check starts the following cycle.

## Configuration
- Macro: KEYED_FSM_TROJAN_EN.
- Defined:
  - trig_cnt increments on each CHK→RUN transition and saturates at TRIG_CNT.
  - The payload is armed when trig_cnt==TRIG_CNT.
  - Once armed, CHK always goes to DUP, even with the correct key.
  - The counter clears only on reset.
- Undefined:
  - trig_cnt and its logic are absent.
  - The payload is never armed; CHK with the correct key always goes to RUN.

## Structure
- Package keyed_fsm_pkg holds:
  - The state enum typedef: IDLE, ACQ, CHK, RUN, DONE, DUP (4-bit encoding).
  - Output constants: Y_IDLE, Y_ACQ, Y_CHK, Y_RUN_BASE, Y_DONE.
  - CORRUPT_MASK = 8'h5A.
- One sub-module, kfsm_trig_cnt: a saturating counter with an armed output, instantiated only under KEYED_FSM_TROJAN_EN.

## Test plan
- Reset: rst_n=0 for any number of cycles mid-stream → y=8'h00 and done=0 immediately; after release the block idles until x[0]=1.
- Correct key 4'hA, sequence x=0001, x=0010, then two RUN cycles with x=0100, then x=1000:
  - RUN cycles show y=8'hA4.
  - DONE shows y=8'hFF with done=1 for one cycle, then IDLE.
- Wrong key 4'h3, same sequence with 5 cycles in DUP at x=0100:
  - First 3 DUP cycles show y=8'hA4.
  - Cycles 4–5 show y=8'hFE.
  - x=1000 returns to IDLE; done stays 0.
- KEYED_FSM_TROJAN_EN defined, TRIG_CNT=5:
  - Five correct-key runs complete normally.
  - The sixth behaves exactly like the wrong-key case.
  - With the macro undefined, the sixth run completes normally.
- Reset in DUP: pull rst_n low at DUP cycle 4 → y=8'h00 at once; after release, a correct-key run reaches DONE with done=1 (trig_cnt was cleared).
- Key toggling: change keyinput from 4'hA to 4'h0 during RUN → no effect; y still follows 8'hA0|x_q until DONE.
